// File: rtl/uart_cipher_ctrl_pkg.sv
// Shared types and constants for the UART <-> block-cipher command controller.
package uart_cipher_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RX_KEY  = 3'd1,
    ST_RX_TEXT = 3'd2,
    ST_START   = 3'd3,
    ST_WAIT    = 3'd4,
    ST_TX_RES  = 3'd5,
    ST_TX_TEXT = 3'd6
  } state_t;

  // Command byte layout: bit0 selects decrypt, bit1 selects crypt (else key load).
  localparam int CMD_DEC   = 0;
  localparam int CMD_CRYPT = 1;

  // Error status codes returned in place of the command echo.
  localparam logic [7:0] STAT_BAD_CMD = 8'h80;
  localparam logic [7:0] STAT_TIMEOUT = 8'h81;
  localparam logic [7:0] STAT_NO_KEY  = 8'h82;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Byte counter width; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_cipher_ctrl_if.sv
// UART RX/TX and cipher-core signal bundle seen by the controller.
interface uart_cipher_ctrl_if #(
  parameter int KEY_BYTES   = 16,
  parameter int BLOCK_BYTES = 16
);
  logic                     i_Rx_fDone;
  logic [7:0]               i_Rx_Data;
  logic                     o_fTx;
  logic [7:0]               o_Tx_Data;
  logic                     i_Tx_fRdy;
  logic                     i_Tx_fDone;
  logic                     o_Core_fStart;
  logic                     o_Core_fDec;
  logic [KEY_BYTES*8-1:0]   o_Core_Key;
  logic [BLOCK_BYTES*8-1:0] o_Core_Text;
  logic                     i_Core_fDone;
  logic [BLOCK_BYTES*8-1:0] i_Core_Text;

  // Controller side.
  modport master (
    input  i_Rx_fDone, i_Rx_Data, i_Tx_fRdy, i_Tx_fDone, i_Core_fDone, i_Core_Text,
    output o_fTx, o_Tx_Data, o_Core_fStart, o_Core_fDec, o_Core_Key, o_Core_Text
  );

  // UART / core side.
  modport slave (
    output i_Rx_fDone, i_Rx_Data, i_Tx_fRdy, i_Tx_fDone, i_Core_fDone, i_Core_Text,
    input  o_fTx, o_Tx_Data, o_Core_fStart, o_Core_fDec, o_Core_Key, o_Core_Text
  );
endinterface

// File: rtl/uart_cipher_ctrl_timeout.sv
// Inter-byte watchdog: counts enabled idle cycles and flags when the limit is reached.
module ctrl_timeout #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int TW = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] cnt;
  logic          at_limit;

  assign at_limit = (cnt == TW'(TIMEOUT_CYC));
  // A zero limit means the watchdog never fires.
  assign expire   = (TIMEOUT_CYC != 0) && en && at_limit;

  // Idle-cycle counter; parks at the limit so it cannot wrap.
  always_ff @(posedge clk) begin
    if (!rst_n || clr || !en) cnt <= '0;
    else if (!at_limit)       cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/uart_cipher_ctrl.sv
// Byte-stream command framing between the UART pair and a block-cipher core.
module uart_cipher_ctrl
  import uart_cipher_ctrl_pkg::*;
#(
  parameter int KEY_BYTES   = 16,
  parameter int BLOCK_BYTES = 16,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  uart_cipher_ctrl_if.master  bus,
  output logic [2:0]          o_State,
  output logic [7:0]          o_Err_Cnt
);
  localparam int MAXB = max2(KEY_BYTES, BLOCK_BYTES);
  localparam int CW   = cnt_w(MAXB);
  localparam int KW   = KEY_BYTES * 8;
  localparam int BW   = BLOCK_BYTES * 8;
  localparam int MW   = MAXB * 8;

  state_t         state, next;
  logic [CW-1:0]  byte_cnt;
  logic [MW-1:0]  rx_buf, rx_next;
  logic [KW-1:0]  key_reg;
  logic [BW-1:0]  text_reg;
  logic [1:0]     cmd;
  logic [7:0]     status, tx_data, err_cnt;
  logic           key_valid, tx_pend, ftx, core_start;
  logic           in_rx, in_tx, rx_ok, last_key, last_text;
  logic           tx_ack, tx_fire, crypt_ok, bad_cmd, no_key;
  logic           expire, tmo_clr, err_evt;

  assign in_rx     = (state == ST_RX_KEY) || (state == ST_RX_TEXT);
  assign in_tx     = (state == ST_TX_RES) || (state == ST_TX_TEXT);
  assign rx_ok     = in_rx && bus.i_Rx_fDone;
  assign last_key  = (byte_cnt == CW'(KEY_BYTES - 1));
  assign last_text = (byte_cnt == CW'(BLOCK_BYTES - 1));
  assign tx_ack    = in_tx && tx_pend && bus.i_Tx_fDone;
  assign tx_fire   = in_tx && !tx_pend && bus.i_Tx_fRdy;
  assign crypt_ok  = !status[7] && cmd[CMD_CRYPT];
  assign bad_cmd   = |bus.i_Rx_Data[7:2];
  assign no_key    = bus.i_Rx_Data[CMD_CRYPT] && !key_valid;
  // Incoming bytes land in the LSB so the first byte ends up in the MSB.
  assign rx_next   = (rx_buf << 8) | MW'(bus.i_Rx_Data);
  // Watchdog restarts on every accepted byte and on any state change.
  assign tmo_clr   = rx_ok || (state != next);

  ctrl_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk    (i_Clk),
    .rst_n  (i_Rst),
    .clr    (tmo_clr),
    .en     (in_rx),
    .expire (expire)
  );

  // State register.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst) state <= ST_IDLE;
    else        state <= next;
  end

  // Next-state logic; a byte in the expiry cycle takes priority over the timeout.
  always_comb begin
    next = state;
    case (state)
      ST_IDLE: if (bus.i_Rx_fDone) begin
        if (bad_cmd || no_key)                next = ST_TX_RES;
        else if (bus.i_Rx_Data[CMD_CRYPT])    next = ST_RX_TEXT;
        else                                  next = ST_RX_KEY;
      end
      ST_RX_KEY: begin
        if (bus.i_Rx_fDone) begin
          if (last_key) next = ST_TX_RES;
        end else if (expire) next = ST_TX_RES;
      end
      ST_RX_TEXT: begin
        if (bus.i_Rx_fDone) begin
          if (last_text) next = ST_START;
        end else if (expire) next = ST_TX_RES;
      end
      ST_START:   next = ST_WAIT;
      ST_WAIT:    if (bus.i_Core_fDone) next = ST_TX_RES;
      ST_TX_RES:  if (tx_ack) next = crypt_ok ? ST_TX_TEXT : ST_IDLE;
      ST_TX_TEXT: if (tx_ack && last_text) next = ST_IDLE;
      default:    next = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    core_start = (state == ST_START);
    o_State    = state;
  end

  // Error responses: malformed command, crypt without key, inter-byte timeout.
  always_comb begin
    err_evt = 1'b0;
    if (state == ST_IDLE && bus.i_Rx_fDone && (bad_cmd || no_key)) err_evt = 1'b1;
    if (in_rx && !bus.i_Rx_fDone && expire)                        err_evt = 1'b1;
  end

  // Byte counter: per received/transmitted byte, cleared on every state change.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst || state != next)                           byte_cnt <= '0;
    else if (rx_ok || (state == ST_TX_TEXT && tx_ack))     byte_cnt <= byte_cnt + 1'b1;
  end

  // Saturating error counter.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst)                          err_cnt <= '0;
    else if (err_evt && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end

  // Datapath: command latch, frame assembly, core result capture, TX handshake.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      rx_buf    <= '0;
      key_reg   <= '0;
      text_reg  <= '0;
      cmd       <= '0;
      status    <= '0;
      key_valid <= 1'b0;
      tx_pend   <= 1'b0;
      ftx       <= 1'b0;
      tx_data   <= '0;
    end else begin
      ftx <= 1'b0;
      case (state)
        ST_IDLE: if (bus.i_Rx_fDone) begin
          if (bad_cmd)     status <= STAT_BAD_CMD;
          else if (no_key) status <= STAT_NO_KEY;
          else             cmd    <= bus.i_Rx_Data[1:0];
        end
        ST_RX_KEY, ST_RX_TEXT: begin
          if (bus.i_Rx_fDone) begin
            rx_buf <= rx_next;
            if (state == ST_RX_KEY && last_key) begin
              key_reg   <= rx_next[KW-1:0];
              key_valid <= 1'b1;
              status    <= {6'b0, cmd};
            end else if (state == ST_RX_TEXT && last_text) begin
              text_reg <= rx_next[BW-1:0];
            end
          end else if (expire) begin
            status <= STAT_TIMEOUT;
          end
        end
        ST_WAIT: if (bus.i_Core_fDone) begin
          text_reg <= bus.i_Core_Text;
          status   <= {6'b0, cmd};
        end
        ST_TX_RES, ST_TX_TEXT: begin
          if (tx_ack) begin
            tx_pend <= 1'b0;
            if (state == ST_TX_TEXT) text_reg <= text_reg << 8;
          end else if (tx_fire) begin
            ftx     <= 1'b1;
            tx_pend <= 1'b1;
            tx_data <= (state == ST_TX_RES) ? status : text_reg[BW-1 -: 8];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_fTx         = ftx;
  assign bus.o_Tx_Data     = tx_data;
  assign bus.o_Core_fStart = core_start;
  assign bus.o_Core_fDec   = cmd[CMD_DEC];
  assign bus.o_Core_Key    = key_reg;
  assign bus.o_Core_Text   = text_reg;
  assign o_Err_Cnt         = err_cnt;
endmodule
